// File: rtl/btn_pkg.sv
// Shared state encoding and default timing constants for the button gesture decoder.
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS    = 3'd1,
        HELD     = 3'd2,
        WAIT_DBL = 3'd3,
        WAIT_REL = 3'd4
    } btn_state_e;

    localparam int F_COUNT_DEF   = 100000;
    localparam int LONG_MS_DEF   = 1000;
    localparam int REPEAT_MS_DEF = 200;
    localparam int DBL_MS_DEF    = 300;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_tick_gen.sv
// Millisecond prescaler: one-cycle tick every F_COUNT clocks, restartable by clr_i.
module btn_tick_gen
    import btn_pkg::*;
#(
    parameter int F_COUNT = F_COUNT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (F_COUNT > 1) ? $clog2(F_COUNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(F_COUNT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/btn_press_decoder.sv
// Turns a debounced button level into short/long/repeat (and, with
// BTN_DOUBLE_CLICK_EN defined, double-click) one-cycle gesture pulses.
//
// state    | meaning
// IDLE     | button released, waiting for a press edge
// PRESS    | pressed, timing toward the long-press threshold
// HELD     | long press fired, emitting auto-repeat pulses
// WAIT_DBL | released after a short press, waiting for a second press
// WAIT_REL | double click reported, waiting for release
module btn_press_decoder
    import btn_pkg::*;
#(
    parameter int F_COUNT   = F_COUNT_DEF,
    parameter int LONG_MS   = LONG_MS_DEF,
    parameter int REPEAT_MS = REPEAT_MS_DEF,
    parameter int DBL_MS    = DBL_MS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_short,
    output logic o_long,
    output logic o_repeat,
    output logic o_held,
    output logic o_double
);

    localparam int MS_W = $clog2(max3(LONG_MS, REPEAT_MS, DBL_MS) + 1);
    localparam logic [MS_W-1:0] LONG_TH = MS_W'(LONG_MS - 1);
    localparam logic [MS_W-1:0] REP_TH  = MS_W'(REPEAT_MS - 1);
`ifdef BTN_DOUBLE_CLICK_EN
    localparam logic [MS_W-1:0] DBL_TH  = MS_W'(DBL_MS - 1);
`endif

    btn_state_e      state_q, state_d;
    logic [MS_W-1:0] ms_q, ms_d;
    logic            r_btn_q;
    logic            short_q, short_d;
    logic            long_q, long_d;
    logic            rep_q, rep_d;
    logic            held_q;
    logic            dbl_d;
    logic            press, tick, clr;

    assign press = i_btn & ~r_btn_q;
    // Restarting the prescaler on every transition makes gesture latency exact.
    assign clr   = (state_d != state_q);

    btn_tick_gen #(.F_COUNT(F_COUNT)) u_tick (
        .clk    (clk),
        .rst_n  (rst),
        .clr_i  (clr),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        ms_d    = ms_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
        dbl_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (press) state_d = PRESS;
            end
            PRESS: begin
                if (tick) ms_d = ms_q + 1'b1;
                if (!i_btn) begin
`ifdef BTN_DOUBLE_CLICK_EN
                    state_d = WAIT_DBL;
`else
                    short_d = 1'b1;
                    state_d = IDLE;
`endif
                end else if (tick && ms_q == LONG_TH) begin
                    long_d  = 1'b1;
                    state_d = HELD;
                end
            end
            HELD: begin
                if (tick) ms_d = ms_q + 1'b1;
                if (!i_btn) begin
                    state_d = IDLE;
                end else if (tick && ms_q == REP_TH) begin
                    rep_d = 1'b1;
                    ms_d  = '0;
                end
            end
`ifdef BTN_DOUBLE_CLICK_EN
            WAIT_DBL: begin
                if (tick) ms_d = ms_q + 1'b1;
                if (press) begin
                    dbl_d   = 1'b1;
                    state_d = WAIT_REL;
                end else if (tick && ms_q == DBL_TH) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_REL: begin
                if (!i_btn) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) ms_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ms_q    <= '0;
            r_btn_q <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ms_q    <= ms_d;
            r_btn_q <= i_btn;
            short_q <= short_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
            held_q  <= (state_d == HELD);
        end
    end

`ifdef BTN_DOUBLE_CLICK_EN
    logic dbl_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbl_q <= 1'b0;
        end else begin
            dbl_q <= dbl_d;
        end
    end

    assign o_double = dbl_q;
`else
    logic unused_dbl;
    assign unused_dbl = dbl_d;
    assign o_double   = 1'b0;
`endif

    assign o_short  = short_q;
    assign o_long   = long_q;
    assign o_repeat = rep_q;
    assign o_held   = held_q;

endmodule

// File: tb/tb_btn_press_decoder.sv
// Directed, table-driven bench for btn_press_decoder (F_COUNT=4, LONG_MS=3,
// REPEAT_MS=2, DBL_MS=3); expectations follow BTN_DOUBLE_CLICK_EN when defined.
module tb_btn_press_decoder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic i_btn = 1'b0;
    logic o_short, o_long, o_repeat, o_held, o_double;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    btn_press_decoder #(
        .F_COUNT   (4),
        .LONG_MS   (3),
        .REPEAT_MS (2),
        .DBL_MS    (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_btn    (i_btn),
        .o_short  (o_short),
        .o_long   (o_long),
        .o_repeat (o_repeat),
        .o_held   (o_held),
        .o_double (o_double)
    );

    // Cycle numbers are relative to the first cycle the button is high.
    typedef struct {
        string name;
        int    on1, off1, on2, off2;
        int    ncyc;
        int    e_short, e_long, e_dbl;
        int    held_lo, held_hi;
        int    rep0, rep1, rep2;
    } vec_t;

    vec_t vq[$];

    function automatic logic [4:0] outs();
        return {o_short, o_long, o_repeat, o_held, o_double};
    endfunction

    task automatic chk(input string nm, input int cyc, input logic [4:0] got, input logic [4:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got short/long/rep/held/dbl=%b expected %b", nm, cyc, got, exp);
        end
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 i_btn = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [4:0] exp;
        for (int c = 0; c < v.ncyc; c++) begin
            @(posedge clk);
            #1 i_btn = (c >= v.on1 && c <= v.off1) || (c >= v.on2 && c <= v.off2);
            @(negedge clk);
            exp = {c == v.e_short, c == v.e_long,
                   (c == v.rep0) || (c == v.rep1) || (c == v.rep2),
                   (c >= v.held_lo) && (c <= v.held_hi), c == v.e_dbl};
            chk(v.name, c, outs(), exp);
        end
    endtask

    initial begin
        logic [4:0] exp;

        vq.push_back('{"long_hold", 0, 40, -1, -1, 46, -1, 13, -1, 13, 41, 21, 29, 37});
        vq.push_back('{"long_then_release", 0, 12, -1, -1, 18, -1, 13, -1, 13, 13, -1, -1, -1});
        vq.push_back('{"repeat_release_race", 0, 19, -1, -1, 26, -1, 13, -1, 13, 20, -1, -1, -1});
`ifdef BTN_DOUBLE_CLICK_EN
        vq.push_back('{"short_press", 0, 5, -1, -1, 24, 19, -1, -1, -1, -1, -1, -1, -1});
        vq.push_back('{"long_release_race", 0, 11, -1, -1, 30, 25, -1, -1, -1, -1, -1, -1, -1});
        vq.push_back('{"early_release", 0, 10, -1, -1, 30, 24, -1, -1, -1, -1, -1, -1, -1});
        vq.push_back('{"double_click", 0, 2, 6, 8, 20, -1, -1, 7, -1, -1, -1, -1, -1});
        vq.push_back('{"single_timeout", 0, 2, -1, -1, 22, 16, -1, -1, -1, -1, -1, -1, -1});
        vq.push_back('{"dbl_timeout_race", 0, 2, 15, 16, 22, -1, -1, 16, -1, -1, -1, -1, -1});
`else
        vq.push_back('{"short_press", 0, 5, -1, -1, 14, 7, -1, -1, -1, -1, -1, -1, -1});
        vq.push_back('{"long_release_race", 0, 11, -1, -1, 16, 13, -1, -1, -1, -1, -1, -1, -1});
        vq.push_back('{"early_release", 0, 10, -1, -1, 16, 12, -1, -1, -1, -1, -1, -1, -1});
`endif

        // Held in reset while the button toggles: nothing may come out.
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1 i_btn = c[0];
            @(negedge clk);
            chk("in_reset", c, outs(), 5'b0);
        end
        @(posedge clk);
        #1 i_btn = 1'b0;
        rst = 1'b1;
        idle_gap(10);

        foreach (vq[i]) begin
            run_vec(vq[i]);
            idle_gap(20);
        end

        // Reset mid-hold with the button kept down: old gesture dies, a fresh
        // press is seen at reset release (cycle 13), so o_long lands at 26.
        for (int c = 0; c < 31; c++) begin
            @(posedge clk);
            #1 i_btn = 1'b1;
            if (c == 10) rst = 1'b0;
            if (c == 13) rst = 1'b1;
            @(negedge clk);
            exp = {1'b0, c == 26, 1'b0, c >= 26, 1'b0};
            chk("reset_mid_hold", c, outs(), exp);
        end
        idle_gap(3);
        @(negedge clk);
        chk("held_after_release", 0, outs(), 5'b0);
        idle_gap(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
